seq_array_streamer: RTL and testbench

//  Transmit side of the sequential array adder. Holds a DEPTH x NIB_W array and

---
 rtl/seq_add_pkg.sv | 19 +
 rtl/seq_array_streamer_if.sv | 39 +++
 rtl/seq_nib_select.sv | 12 +
 rtl/seq_array_streamer.sv | 130 +++++++++++++
 tb/tb_seq_array_streamer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_add_pkg.sv
// Shared parameters and FSM state encoding for the sequential array adder
// (streamer and accumulator side).
package seq_add_pkg;

    localparam int NIB_W = 4;
    localparam int DEPTH = 128;
    localparam int IDX_W = 7;
    localparam int SUM_W = 12;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/seq_array_streamer_if.sv
// Load/stream bundle between the array source, the streamer and the accumulator.
// SEQ_STREAM_SUM_EN adds the exp_sum reference-sum signal.
interface seq_array_streamer_if;
    import seq_add_pkg::*;

    logic                   load;
    logic [DEPTH*NIB_W-1:0] arr_in;
    logic [NIB_W-1:0]       mask_in;
    logic                   start;
    logic                   nib_ready;
    logic [NIB_W-1:0]       nib_out;
    logic [NIB_W-1:0]       check_out;
    logic                   nib_valid;
    logic [IDX_W-1:0]       idx;
    logic                   busy;
    logic                   done;
`ifdef SEQ_STREAM_SUM_EN
    logic [SUM_W-1:0]       exp_sum;

    modport master (
        output load, arr_in, mask_in, start, nib_ready,
        input  nib_out, check_out, nib_valid, idx, busy, done, exp_sum
    );
    modport slave (
        input  load, arr_in, mask_in, start, nib_ready,
        output nib_out, check_out, nib_valid, idx, busy, done, exp_sum
    );
`else
    modport master (
        output load, arr_in, mask_in, start, nib_ready,
        input  nib_out, check_out, nib_valid, idx, busy, done
    );
    modport slave (
        input  load, arr_in, mask_in, start, nib_ready,
        output nib_out, check_out, nib_valid, idx, busy, done
    );
`endif

endinterface

// File: rtl/seq_nib_select.sv
// Combinational DEPTH:1 element mux: picks element idx out of the packed array.
module seq_nib_select
    import seq_add_pkg::*;
(
    input  logic [DEPTH*NIB_W-1:0] arr,
    input  logic [IDX_W-1:0]       idx,
    output logic [NIB_W-1:0]       nib
);

    assign nib = arr[idx*NIB_W +: NIB_W];

endmodule

// File: rtl/seq_array_streamer.sv
// Transmit side of the sequential array adder: holds the array and streams one
// masked nibble per handshake. SEQ_STREAM_SUM_EN adds the exp_sum reference sum.
module seq_array_streamer
    import seq_add_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    seq_array_streamer_if.slave  bus
);

    state_e                 state_r, state_nx_s;
    logic [DEPTH*NIB_W-1:0] arr_r;
    logic [NIB_W-1:0]       mask_r;
    logic [NIB_W-1:0]       check_r;
    logic [NIB_W-1:0]       nib_s;
    logic [IDX_W-1:0]       idx_r, idx_nx_s;
    logic                   valid_r;
    logic                   done_r;
    logic                   cap_s;
    logic                   hs_s;

    seq_nib_select u_sel (
        .arr (arr_r),
        .idx (idx_r),
        .nib (nib_s)
    );

    assign hs_s = valid_r & bus.nib_ready;

    // Next-state, index and capture decode
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        cap_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.load) begin
                    state_nx_s = ST_LOADED;
                    idx_nx_s   = '0;
                    cap_s      = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOADED: begin
                // load takes priority over a simultaneous start
                if (bus.load) begin
                    state_nx_s = ST_LOADED;
                    idx_nx_s   = '0;
                    cap_s      = 1'b1;
                end else if (bus.start) begin
                    state_nx_s = ST_STREAM;
                    idx_nx_s   = '0;
                end else begin
                    state_nx_s = ST_LOADED;
                end
            end
            ST_STREAM: begin
                if (hs_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        idx_nx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_nx_s = ST_STREAM;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_LOADED;
            end
            default: begin
                state_nx_s = ST_IDLE;
                idx_nx_s   = '0;
            end
        endcase
    end

    // State, storage and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            arr_r   <= '0;
            mask_r  <= '0;
            idx_r   <= '0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            check_r <= '0;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            if (cap_s) begin
                arr_r  <= bus.arr_in;
                mask_r <= bus.mask_in;
            end
            // mask_r never changes on a cycle that enters STREAM, so it is safe here
            valid_r <= (state_nx_s == ST_STREAM);
            done_r  <= (state_nx_s == ST_DONE);
            check_r <= (state_nx_s == ST_STREAM) ? mask_r : {NIB_W{1'b0}};
        end
    end

    assign bus.nib_out   = nib_s;
    assign bus.check_out = check_r;
    assign bus.nib_valid = valid_r;
    assign bus.idx       = idx_r;
    assign bus.busy      = valid_r;
    assign bus.done      = done_r;

`ifdef SEQ_STREAM_SUM_EN
    logic [SUM_W-1:0] sum_r;
    logic             sum_clr_s;

    assign sum_clr_s = (state_r == ST_LOADED) & bus.start & ~bus.load;

    // Reference sum of the masked elements actually handed to the accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= '0;
        end else if (sum_clr_s) begin
            sum_r <= '0;
        end else if (hs_s) begin
            sum_r <= sum_r + SUM_W'(nib_s & mask_r);
        end
    end

    assign bus.exp_sum = sum_r;
`endif

endmodule

// File: tb/tb_seq_array_streamer.sv
// Self-checking bench for seq_array_streamer: control vector table plus
// scoreboard-checked full streams.
module tb_seq_array_streamer;
    import seq_add_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_array_streamer_if bus();

    seq_array_streamer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic             rst;
        logic             load;
        logic             start;
        logic             ready;
        logic [3:0]       mask;
        logic             v;
        logic             b;
        logic             d;
        logic [IDX_W-1:0] idx;
        logic [3:0]       nib;
        logic [3:0]       chk;
    } vec_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [NIB_W-1:0] nib;
    } sb_t;

    int tests = 0;
    int fails = 0;
    logic [NIB_W-1:0] model_arr [DEPTH];
    logic [NIB_W-1:0] model_mask = 4'h0;
    int               model_sum = 0;
    sb_t              sb_q [$];
    vec_t             vec [11];
    int               vcnt, dcyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [DEPTH*NIB_W-1:0] build_arr(input int pat);
        logic [DEPTH*NIB_W-1:0] a;
        logic [6:0] i7;
        a = '0;
        for (int i = 0; i < DEPTH; i++) begin
            i7 = 7'(i);
            case (pat)
                0:       a[i*NIB_W +: NIB_W] = 4'hF;
                1:       a[i*NIB_W +: NIB_W] = i7[3:0];
                default: a[i*NIB_W +: NIB_W] = ~i7[3:0];
            endcase
        end
        return a;
    endfunction

    task automatic load_data(input int pat, input logic [3:0] mask);
        bus.arr_in  = build_arr(pat);
        bus.mask_in = mask;
        bus.load    = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_arr[i] = bus.arr_in[i*NIB_W +: NIB_W];
        model_mask = mask;
        step();
        bus.load = 1'b0;
        check("load_valid", bus.nib_valid, 0);
        check("load_idx", bus.idx, 0);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        model_sum = 0;
        for (int i = 0; i < DEPTH; i++) begin
            sb_q.push_back({7'(i), model_arr[i]});
            model_sum += int'(model_arr[i] & model_mask);
        end
        step();
        bus.start = 1'b0;
        check("start_valid", bus.nib_valid, 1);
        check("start_idx", bus.idx, 0);
        check("start_busy", bus.busy, 1);
    endtask

    // mode 0: ready always 1, 1: toggling, 2: random
    task automatic run_stream(input int mode, input bit disturb, output int valid_cnt, output int done_cyc);
        logic hs, r;
        logic [NIB_W-1:0] nib_v;
        logic [IDX_W-1:0] idx_v;
        int n_done;
        sb_t e;
        n_done = 0;
        valid_cnt = 0;
        done_cyc = -1;
        for (int k = 0; k < 2000 && n_done == 0; k++) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (k % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.nib_ready = r;
            if (disturb && k >= 10 && k < 16) begin
                bus.load    = 1'b1;
                bus.start   = 1'b1;
                bus.arr_in  = build_arr(2);
                bus.mask_in = 4'h0;
            end else begin
                bus.load  = 1'b0;
                bus.start = 1'b0;
            end
            hs    = bus.nib_valid & r;
            nib_v = bus.nib_out;
            idx_v = bus.idx;
            if (bus.nib_valid) valid_cnt++;
            step();
            if (hs) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: handshake at idx %0d with no expected element", idx_v);
                end else begin
                    e = sb_q.pop_front();
                    check("stream_idx", idx_v, e.idx);
                    check("stream_nib", nib_v, e.nib);
                end
            end
            if (bus.nib_valid) check("check_out_valid", bus.check_out, model_mask);
            else               check("check_out_idle", bus.check_out, 0);
            if (bus.done) begin
                n_done++;
                done_cyc = k + 2;
            end
        end
        bus.load  = 1'b0;
        bus.start = 1'b0;
        check("stream_done_seen", n_done, 1);
        check("sb_empty", sb_q.size(), 0);
        check("done_valid_low", bus.nib_valid, 0);
`ifdef SEQ_STREAM_SUM_EN
        check("exp_sum", bus.exp_sum, model_sum);
`endif
        step();
        check("done_one_cycle", bus.done, 0);
        check("after_done_busy", bus.busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.load = 1'b0; bus.start = 1'b0; bus.nib_ready = 1'b0;
        bus.arr_in = '0; bus.mask_in = 4'h0;

        // Test 1: reset held 3 cycles with start asserted
        bus.start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_valid", bus.nib_valid, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
            check("rst_idx", bus.idx, 0);
            check("rst_check", bus.check_out, 0);
            check("rst_nib", bus.nib_out, 0);
        end
        rst = 1'b0;
        step();
        bus.start = 1'b0;
        check("idle_start_ignored", bus.busy, 0);

        // Control vector table
        vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0, 4'h0};
        vec[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0, 4'h0};
        vec[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0, 4'h0};
        vec[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0, 4'h0};
        vec[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0, 7'd0, 4'h0, 4'h3};
        vec[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0, 7'd0, 4'h0, 4'h3};
        vec[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 7'd1, 4'h1, 4'h3};
        vec[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 7'd2, 4'h2, 4'h3};
        vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 7'd2, 4'h2, 4'h3};
        vec[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0, 4'h0};
        vec[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0, 4'h0};
        bus.arr_in = build_arr(1);
        for (int r = 0; r < 11; r++) begin
            rst           = vec[r].rst;
            bus.load      = vec[r].load;
            bus.start     = vec[r].start;
            bus.nib_ready = vec[r].ready;
            bus.mask_in   = vec[r].mask;
            step();
            check($sformatf("vec%0d_valid", r), bus.nib_valid, vec[r].v);
            check($sformatf("vec%0d_busy", r), bus.busy, vec[r].b);
            check($sformatf("vec%0d_done", r), bus.done, vec[r].d);
            check($sformatf("vec%0d_idx", r), bus.idx, vec[r].idx);
            check($sformatf("vec%0d_nib", r), bus.nib_out, vec[r].nib);
            check($sformatf("vec%0d_check", r), bus.check_out, vec[r].chk);
        end
        rst = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.nib_ready = 1'b0;

        // Test 2: all-F, mask F, ready=1
        load_data(0, 4'hF);
        do_start();
        run_stream(0, 1'b0, vcnt, dcyc);
        check("t2_valid_cycles", vcnt, DEPTH);
        check("t2_done_cycle", dcyc, DEPTH + 1);
`ifdef SEQ_STREAM_SUM_EN
        check("t2_sum_const", bus.exp_sum, 12'h780);
`endif

        // Test 4: replay with ready toggling
        do_start();
        run_stream(1, 1'b0, vcnt, dcyc);

        // Test 3: element i = i[3:0], mask 3
        load_data(1, 4'h3);
        do_start();
        run_stream(0, 1'b0, vcnt, dcyc);
        check("t3_valid_cycles", vcnt, DEPTH);
`ifdef SEQ_STREAM_SUM_EN
        check("t3_sum_const", bus.exp_sum, 12'd192);
`endif

        // Test 6: load/start during STREAM ignored, then random-ready replay
        load_data(2, 4'hA);
        do_start();
        run_stream(0, 1'b1, vcnt, dcyc);
        check("t6_valid_cycles", vcnt, DEPTH);
        do_start();
        run_stream(2, 1'b0, vcnt, dcyc);

        // Test 5: reset mid-stream at idx 50
        load_data(1, 4'h3);
        do_start();
        bus.nib_ready = 1'b1;
        for (int k = 0; k < 200 && bus.idx != 7'd50; k++) step();
        check("t5_reached_idx50", bus.idx, 50);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
        check("t5_rst_valid", bus.nib_valid, 0);
        check("t5_rst_check", bus.check_out, 0);
        check("t5_rst_idx", bus.idx, 0);
        check("t5_rst_busy", bus.busy, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("t5_start_ignored", bus.nib_valid, 0);
        step();
        check("t5_still_idle", bus.busy, 0);
        load_data(1, 4'h3);
        do_start();
        run_stream(0, 1'b0, vcnt, dcyc);
        check("t5_reload_done_cycle", dcyc, DEPTH + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
